dp_controller: RTL and testbench
================================

DP_CONTROLLER -- requirements
Module: dp_controller

Interface
REQ-001 SHALL have port clk, input, 1, single system clock, rising edge active.
REQ-002 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port I, input, 32, current instruction register contents.
REQ-004 SHALL have port NZCV, input, 4, current flags {N,Z,C,V}.
REQ-005 SHALL have ports Write_PC, Write_IR, Write_Reg, outputs, 1 each, datapath write strobes.
REQ-006 SHALL have ports LA, LB, LC, LF, outputs, 1 each, latch enables for operand registers A/B/C and result F.
REQ-007 SHALL have port S, output, 1, flag-update enable.
REQ-008 SHALL have port rm_imm_s, output, 1, 1 = shifter operand is rotated imm8.
REQ-009 SHALL have port rs_imm_s, output, 2, shift-amount select: 00 = Rs[7:0], 01 = I[11:8]*2, 10 = I[11:7].
REQ-010 SHALL have port ALU_OP, output, 4, ARM DP opcode.
REQ-011 SHALL have port SHIFT_OP, output, 3, shifter operation code.
REQ-012 SHALL have port state, output, 3, current FSM state (debug).

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, EXEC, WB; all strobes SHALL be decoded from the state register and I only.
REQ-014 IDLE: all strobes 0; next state FETCH.
REQ-015 FETCH: Write_PC=1, Write_IR=1; next state DECODE.
REQ-016 DECODE: evaluate cond I[31:28] against NZCV.
- Cond fail, or I[27:26]!=00 (non-DP): all strobes 0, next state FETCH.
- Otherwise: LA=LB=LC=1, next state EXEC.
REQ-017 Cond table: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 SHALL evaluate as never.
REQ-018 EXEC: LF=1; S=I[20], forced 1 when I[24:23]=10 (TST/TEQ/CMP/CMN).
- Next state FETCH for compare-class opcodes.
- Next state WB for all others.
REQ-019 WB: Write_Reg=1; next state FETCH.
REQ-020 ALU_OP SHALL equal I[24:21] in DECODE and EXEC; 0 elsewhere.
REQ-021 Operand select, in DECODE and EXEC:
- I[25]=1: rm_imm_s=1, rs_imm_s=01, SHIFT_OP=111 (ROR).
- I[25]=0, I[4]=0: rm_imm_s=0, rs_imm_s=10, SHIFT_OP={I[6:5],0}.
- I[25]=0, I[4]=1: rm_imm_s=0, rs_imm_s=00, SHIFT_OP={I[6:5],1}.
REQ-022 Latency SHALL be fixed per class:
- DP with writeback: 4 cycles (FETCH..WB).
- Compare class: 3 cycles.
- Skipped or non-DP: 2 cycles.
REQ-023 Flags sampled in DECODE SHALL be those present at that cycle; a flag update in EXEC SHALL affect only the next instruction.
REQ-024 I SHALL be ignored in IDLE and FETCH.

Reset
REQ-025 Rst=0 SHALL asynchronously force state=IDLE and drive every output to 0, including in mid-instruction.
REQ-026 After Rst deasserts, the first clock edge SHALL move to FETCH; no partial instruction SHALL resume.

Structure
REQ-027 State encodings, SHIFT_OP codes, rs_imm_s codes and cond codes SHALL live in a shared package dp_ctrl_pkg.
REQ-028 Condition evaluation SHALL be a combinational sub-module cond_check(cond[3:0], NZCV, pass).

Verification
REQ-029 I=E2821005 (ADD R1,R2,#5), NZCV=0000 -> states FETCH, DECODE, EXEC, WB; ALU_OP=0100, rm_imm_s=1, rs_imm_s=01, SHIFT_OP=111, S=0; Write_Reg=1 in WB only.
REQ-030 I=E1510002 (CMP R1,R2) -> FETCH, DECODE, EXEC, FETCH; S=1 in EXEC; Write_Reg never 1.
REQ-031 I=00821003 (ADDEQ) with Z=0 -> FETCH, DECODE, FETCH; LA/LB/LC/LF all 0. Same instruction with Z=1 -> 4-cycle sequence.
REQ-032 I=E1A00211 (MOV R0,R1,LSL R2) -> rs_imm_s=00, SHIFT_OP=001, rm_imm_s=0, ALU_OP=1101.
REQ-033 I=E5912000 (LDR, non-DP) -> DECODE returns to FETCH with no strobes; I=F0821005 (cond 1111) -> same.
REQ-034 Rst=0 pulsed during EXEC -> outputs 0 immediately; state=IDLE; FETCH one cycle after release.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the data-processing controller: FSM states, condition codes,
// shifter operand selects and instruction-class helpers.
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Shift-amount source for the barrel shifter.
    localparam logic [1:0] RS_REG      = 2'b00;  // Rs[7:0]
    localparam logic [1:0] RS_IMM8_ROT = 2'b01;  // I[11:8]*2
    localparam logic [1:0] RS_IMM5     = 2'b10;  // I[11:7]

    localparam logic [2:0] SHIFT_ROR_IMM = 3'b111;

    // TST/TEQ/CMP/CMN: opcode[3:2] == 2'b10, result is never written back.
    function automatic logic is_compare(input logic [3:0] opcode);
        return opcode[3:2] == 2'b10;
    endfunction

    function automatic logic is_dp_class(input logic [1:0] op_class);
        return op_class == 2'b00;
    endfunction

endpackage

// File: rtl/dp_controller_if.sv
// Controller <-> datapath bundle: instruction and flags in, strobes and selects out.
interface dp_controller_if;

    logic [31:0] I;
    logic [3:0]  NZCV;
    logic        Write_PC;
    logic        Write_IR;
    logic        Write_Reg;
    logic        LA;
    logic        LB;
    logic        LC;
    logic        LF;
    logic        S;
    logic        rm_imm_s;
    logic [1:0]  rs_imm_s;
    logic [3:0]  ALU_OP;
    logic [2:0]  SHIFT_OP;
    logic [2:0]  state;

    modport master (
        input  I, NZCV,
        output Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S,
               rm_imm_s, rs_imm_s, ALU_OP, SHIFT_OP, state
    );

    modport slave (
        output I, NZCV,
        input  Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S,
               rm_imm_s, rs_imm_s, ALU_OP, SHIFT_OP, state
    );

endinterface

// File: rtl/dp_controller_cond_check.sv
// Combinational ARM condition-code evaluator; 1111 is treated as "never".
module cond_check
    import dp_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] NZCV,
    output logic       pass
);

    logic n, z, c, v;

    assign {n, z, c, v} = NZCV;

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_controller.sv
// Fetch/decode/execute/writeback sequencer for ARM data-processing instructions.
// Strobes and selects decode from the state register and the current instruction.
module dp_controller
    import dp_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            Rst,
    dp_controller_if.master bus
);

    state_e     state_q, state_d;
    logic [3:0] cond;
    logic [3:0] opcode;
    logic [1:0] shift_type;
    logic       imm_op;
    logic       reg_shift;
    logic       s_bit;
    logic       cond_pass;
    logic       dp_go;
    logic       cmp_class;

    assign cond       = bus.I[31:28];
    assign opcode     = bus.I[24:21];
    assign imm_op     = bus.I[25];
    assign s_bit      = bus.I[20];
    assign shift_type = bus.I[6:5];
    assign reg_shift  = bus.I[4];
    assign cmp_class  = is_compare(opcode);
    assign dp_go      = cond_pass && is_dp_class(bus.I[27:26]);

    cond_check u_cond_check (
        .cond (cond),
        .NZCV (bus.NZCV),
        .pass (cond_pass)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = dp_go ? ST_EXEC : ST_FETCH;
            ST_EXEC:   state_d = cmp_class ? ST_FETCH : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset drives state_q to IDLE, which in turn decodes every output to 0.
    always_comb begin
        bus.Write_PC  = 1'b0;
        bus.Write_IR  = 1'b0;
        bus.Write_Reg = 1'b0;
        bus.LA        = 1'b0;
        bus.LB        = 1'b0;
        bus.LC        = 1'b0;
        bus.LF        = 1'b0;
        bus.S         = 1'b0;
        bus.rm_imm_s  = 1'b0;
        bus.rs_imm_s  = 2'b00;
        bus.ALU_OP    = 4'h0;
        bus.SHIFT_OP  = 3'b000;

        if (state_q == ST_DECODE || state_q == ST_EXEC) begin
            bus.ALU_OP = opcode;
            if (imm_op) begin
                bus.rm_imm_s = 1'b1;
                bus.rs_imm_s = RS_IMM8_ROT;
                bus.SHIFT_OP = SHIFT_ROR_IMM;
            end else if (reg_shift) begin
                bus.rs_imm_s = RS_REG;
                bus.SHIFT_OP = {shift_type, 1'b1};
            end else begin
                bus.rs_imm_s = RS_IMM5;
                bus.SHIFT_OP = {shift_type, 1'b0};
            end
        end

        case (state_q)
            ST_FETCH: begin
                bus.Write_PC = 1'b1;
                bus.Write_IR = 1'b1;
            end
            ST_DECODE: begin
                bus.LA = dp_go;
                bus.LB = dp_go;
                bus.LC = dp_go;
            end
            ST_EXEC: begin
                bus.LF = 1'b1;
                bus.S  = s_bit || cmp_class;
            end
            ST_WB: begin
                bus.Write_Reg = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_dp_controller.sv
// Scoreboard bench for dp_controller: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_dp_controller;
    import dp_ctrl_pkg::*;

    localparam int K_SKIP = 0;
    localparam int K_CMP  = 1;
    localparam int K_WB   = 2;

    // Operand-select vectors {rm_imm_s, rs_imm_s, ALU_OP, SHIFT_OP}, decoded by hand.
    localparam logic [9:0] SEL_ADD_IMM = 10'b1_01_0100_111;  // E2821005
    localparam logic [9:0] SEL_CMP     = 10'b0_10_1010_000;  // E1510002
    localparam logic [9:0] SEL_ADD_R3  = 10'b0_10_0100_000;  // x0821003
    localparam logic [9:0] SEL_MOV_LSL = 10'b0_00_1101_001;  // E1A00211
    localparam logic [9:0] SEL_LDR     = 10'b0_10_1100_000;  // E5912000
    localparam logic [9:0] SEL_NV      = 10'b0_10_0100_000;  // F0821005
    localparam logic [9:0] SEL_ADDS_AS = 10'b0_00_0100_101;  // E0912351
    localparam logic [9:0] SEL_TST_ROR = 10'b0_10_1000_110;  // E1000060

    // Strobe vectors {Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S}.
    localparam logic [7:0] STB_NONE   = 8'b0000_0000;
    localparam logic [7:0] STB_FETCH  = 8'b1100_0000;
    localparam logic [7:0] STB_DECODE = 8'b0001_1100;
    localparam logic [7:0] STB_EXEC   = 8'b0000_0010;
    localparam logic [7:0] STB_WB     = 8'b0010_0000;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [7:0] strb;
        logic [9:0] sel;
    } exp_t;

    logic clk = 1'b0;
    logic Rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    dp_controller_if bus ();

    dp_controller dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] strb_now();
        return {bus.Write_PC, bus.Write_IR, bus.Write_Reg, bus.LA, bus.LB, bus.LC, bus.LF, bus.S};
    endfunction

    function automatic logic [9:0] sel_now();
        return {bus.rm_imm_s, bus.rs_imm_s, bus.ALU_OP, bus.SHIFT_OP};
    endfunction

    task automatic push(input string tag, input logic [2:0] st, input logic [7:0] strb,
                        input logic [9:0] sel);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.strb = strb;
        e.sel  = sel;
        exp_q.push_back(e);
    endtask

    // One clock: drive this cycle's inputs just after the edge and queue what the DUT must show.
    task automatic step(input string tag, input logic [31:0] instr, input logic [3:0] nzcv,
                        input logic [2:0] st, input logic [7:0] strb, input logic [9:0] sel);
        @(posedge clk);
        #1;
        bus.I    = instr;
        bus.NZCV = nzcv;
        push(tag, st, strb, sel);
    endtask

    // Flags are inverted outside DECODE and I is garbage in FETCH, so only DECODE-time values may matter.
    task automatic run(input string name, input logic [31:0] instr, input logic [3:0] nzcv,
                       input int kind, input logic s_exp, input logic [9:0] sel);
        step({name, " fetch"}, 32'hFFFF_FFFF, ~nzcv, ST_FETCH, STB_FETCH, 10'd0);
        step({name, " decode"}, instr, nzcv, ST_DECODE, (kind == K_SKIP) ? STB_NONE : STB_DECODE, sel);
        if (kind != K_SKIP)
            step({name, " exec"}, instr, ~nzcv, ST_EXEC, STB_EXEC | {7'd0, s_exp}, sel);
        if (kind == K_WB)
            step({name, " wb"}, instr, ~nzcv, ST_WB, STB_WB, 10'd0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, " state"}, {29'd0, bus.state}, {29'd0, mon_e.st});
            check({mon_e.tag, " strobes"}, {24'd0, strb_now()}, {24'd0, mon_e.strb});
            check({mon_e.tag, " opsel"}, {22'd0, sel_now()}, {22'd0, mon_e.sel});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst      = 1'b0;
        bus.I    = 32'hE282_1005;
        bus.NZCV = 4'hF;
        #1;
        push("reset", ST_IDLE, STB_NONE, 10'd0);
        @(negedge clk);
        #2 Rst = 1'b1;

        run("ADD imm",     32'hE282_1005, 4'b0000, K_WB,   1'b0, SEL_ADD_IMM);
        run("CMP",         32'hE151_0002, 4'b0000, K_CMP,  1'b1, SEL_CMP);
        run("ADDEQ Z=0",   32'h0082_1003, 4'b0000, K_SKIP, 1'b0, SEL_ADD_R3);
        run("ADDEQ Z=1",   32'h0082_1003, 4'b0100, K_WB,   1'b0, SEL_ADD_R3);
        run("MOV LSL Rs",  32'hE1A0_0211, 4'b1010, K_WB,   1'b0, SEL_MOV_LSL);
        run("LDR",         32'hE591_2000, 4'b0000, K_SKIP, 1'b0, SEL_LDR);
        run("cond NV",     32'hF082_1005, 4'b1111, K_SKIP, 1'b0, SEL_NV);
        run("ADDS ASR Rs", 32'hE091_2351, 4'b0000, K_WB,   1'b1, SEL_ADDS_AS);
        run("TST S=0",     32'hE100_0060, 4'b0000, K_CMP,  1'b1, SEL_TST_ROR);
        run("ADDGT",       32'hC082_1003, 4'b1001, K_WB,   1'b0, SEL_ADD_R3);
        run("ADDLT",       32'hB082_1003, 4'b1001, K_SKIP, 1'b0, SEL_ADD_R3);
        run("ADDHI",       32'h8082_1003, 4'b0110, K_SKIP, 1'b0, SEL_ADD_R3);
        run("ADDLS",       32'h9082_1003, 4'b0110, K_WB,   1'b0, SEL_ADD_R3);
        run("ADDCC",       32'h3082_1003, 4'b0010, K_SKIP, 1'b0, SEL_ADD_R3);
        run("ADDVS",       32'h6082_1003, 4'b0001, K_WB,   1'b0, SEL_ADD_R3);

        // Reset pulse in the middle of EXEC.
        step("rst fetch",  32'hFFFF_FFFF, 4'b0000, ST_FETCH,  STB_FETCH,  10'd0);
        step("rst decode", 32'hE282_1005, 4'b0000, ST_DECODE, STB_DECODE, SEL_ADD_IMM);
        step("rst exec",   32'hE282_1005, 4'b0000, ST_EXEC,   STB_EXEC,   SEL_ADD_IMM);
        @(negedge clk);
        #2 Rst = 1'b0;
        #1;
        check("async rst state", {29'd0, bus.state}, 32'd0);
        check("async rst outputs", {14'd0, strb_now(), sel_now()}, 32'd0);
        step("rst hold", 32'hE282_1005, 4'b0000, ST_IDLE, STB_NONE, 10'd0);
        @(negedge clk);
        #2 Rst = 1'b1;
        run("ADD after rst", 32'hE282_1005, 4'b0000, K_WB, 1'b0, SEL_ADD_IMM);

        @(posedge clk);
        #1;
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
